// File: rtl/decoder3x8_pulse_sequencer_pkg.sv
// Shared types and helpers for the 3-to-8 pulse sequencer: FSM states,
// code/one-hot widths and the binary-to-one-hot decode.
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot3to8(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/decoder3x8_pulse_sequencer_if.sv
// Producer-side code handshake: the producer drives valid/code, the
// sequencer returns ready.
interface decoder3x8_pulse_sequencer_if;
  import decoder_pkg::*;

  logic              in_valid;
  logic [CODE_W-1:0] in_code;
  logic              in_ready;

  modport master (output in_valid, output in_code, input  in_ready);
  modport slave  (input  in_valid, input  in_code, output in_ready);

endinterface

// File: rtl/decoder3x8_pulse_sequencer_fifo.sv
// First-word-fall-through code FIFO; dout always shows the head entry and
// level distinguishes full from empty since the pointers wrap modulo DEPTH.
module decoder_code_fifo
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [CODE_W-1:0]       din,
  input  logic                    pop,
  output logic [CODE_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_level;
  logic              w_push;
  logic              w_pop;

  // Flags come from registered level only, so a pop never frees room for a
  // push in the same cycle.
  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign dout   = r_mem[r_rd];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/decoder3x8_pulse_sequencer.sv
// Decodes queued 3-bit codes into one-hot words, each held HOLD cycles and
// followed by GAP all-zero cycles.
module decoder3x8_pulse_sequencer
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  decoder3x8_pulse_sequencer_if.slave  code_if,
  output logic [ONEHOT_W-1:0]          q,
  output logic                         q_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH):0]       level
);

  localparam int CNT_MAX = (HOLD > GAP) ? ((HOLD > 2) ? HOLD : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ONEHOT_W-1:0] r_q;
  logic                r_q_valid;

  logic [CODE_W-1:0]   w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_start;
  logic                w_done;
  logic                w_pop;

  decoder_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (code_if.in_valid),
    .din   (code_if.in_code),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign w_start = enable && !w_empty;
  assign w_done  = (r_cnt == '0);
  // A pop is allowed from IDLE, or at the last cycle of a word when no gap
  // follows, or at the last gap cycle; this gives back-to-back words for GAP=0.
  assign w_pop   = w_start &&
                   ((r_state == ST_IDLE) ||
                    (w_done && ((r_state == ST_GAP) || ((r_state == ST_DRIVE) && (GAP == 0)))));

  assign code_if.in_ready = !w_full;
  assign busy             = (r_state != ST_IDLE) || !w_empty;
  assign q                = r_q;
  assign q_valid          = r_q_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else if (w_pop) begin
      r_q       <= onehot3to8(w_head);
      r_q_valid <= 1'b1;
      r_cnt     <= HOLD_LD;
      r_state   <= ST_DRIVE;
    end else begin
      case (r_state)
        ST_DRIVE: begin
          if (!w_done) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            if (GAP > 0) begin
              r_cnt   <= GAP_LD;
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (!w_done) r_cnt <= r_cnt - 1'b1;
          else         r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder3x8_pulse_sequencer.sv
// Bench for the pulse sequencer: two instances (HOLD=2/GAP=1 and HOLD=1/GAP=0)
// share stimulus and are checked each cycle against a schedule-level model.
module tb_decoder3x8_pulse_sequencer;

  localparam int DEPTH = 4;
  localparam int NI    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic vin = 1'b0;
  logic [2:0] code = '0;

  logic [NI-1:0][7:0] dq;
  logic [NI-1:0]      dqv;
  logic [NI-1:0]      dbusy;
  logic [NI-1:0]      drdy;
  logic [NI-1:0][2:0] dlvl;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder3x8_pulse_sequencer_if if0 ();
  decoder3x8_pulse_sequencer_if if1 ();
  assign if0.in_valid = vin;
  assign if0.in_code  = code;
  assign if1.in_valid = vin;
  assign if1.in_code  = code;
  assign drdy[0] = if0.in_ready;
  assign drdy[1] = if1.in_ready;

  decoder3x8_pulse_sequencer #(.DEPTH(DEPTH), .HOLD(2), .GAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en), .code_if(if0.slave),
    .q(dq[0]), .q_valid(dqv[0]), .busy(dbusy[0]), .level(dlvl[0])
  );

  decoder3x8_pulse_sequencer #(.DEPTH(DEPTH), .HOLD(1), .GAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en), .code_if(if1.slave),
    .q(dq[1]), .q_valid(dqv[1]), .busy(dbusy[1]), .level(dlvl[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a word started at edge s shows its one-hot for edges s..s+HOLD-1;
  // the next word may start at any edge >= s+HOLD+GAP with enable high and a
  // code that was pushed at an earlier edge.
  int    hold_v [NI] = '{2, 1};
  int    gap_v  [NI] = '{1, 0};
  int    mb     [NI][16];
  int    mhd    [NI];
  int    mcnt   [NI];
  int    cur    [NI];
  bit    has    [NI];
  longint st    [NI];
  longint freet [NI];
  int    acc    [NI];
  longint n = 0;

  initial begin : model
    bit st_ok, push_ok;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0;
        for (int i = 0; i < NI; i++) begin
          mhd[i] = 0; mcnt[i] = 0; has[i] = 0; freet[i] = 0; acc[i] = 0; cur[i] = 0; st[i] = 0;
        end
      end else begin
        n++;
        for (int i = 0; i < NI; i++) begin
          st_ok   = (n >= freet[i]) && en && (mcnt[i] > 0);
          push_ok = vin && (mcnt[i] != DEPTH);
          if (st_ok) begin
            cur[i]   = mb[i][mhd[i]];
            mhd[i]   = (mhd[i] + 1) % 16;
            mcnt[i]  = mcnt[i] - 1;
            st[i]    = n;
            freet[i] = n + hold_v[i] + gap_v[i];
            has[i]   = 1'b1;
          end
          if (push_ok) begin
            mb[i][(mhd[i] + mcnt[i]) % 16] = int'(code);
            mcnt[i] = mcnt[i] + 1;
            acc[i]  = acc[i] + 1;
          end
        end
      end
    end
  end

  int   emitted0 = 0;
  logic prev_qv0 = 1'b0;

  initial begin : compare
    logic [7:0] eq;
    logic [5:0] es;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        emitted0 = 0;
        prev_qv0 = 1'b0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          eq = (has[i] && (n - st[i]) < longint'(hold_v[i])) ? (8'd1 << cur[i]) : 8'h00;
          es = {eq != 8'h00, mcnt[i] != DEPTH, (n < freet[i]) || (mcnt[i] > 0), 3'(mcnt[i])};
          chk($sformatf("cyc_q%0d", i), 32'(dq[i]), 32'(eq));
          chk($sformatf("cyc_status%0d", i), 32'({dqv[i], drdy[i], dbusy[i], dlvl[i]}), 32'(es));
        end
        if (dqv[0] && !prev_qv0) emitted0++;
        prev_qv0 = dqv[0];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seq0 [12] = '{8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00,
                            8'h04, 8'h04, 8'h00, 8'h08, 8'h08, 8'h00};
  logic [7:0] seq1 [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin : stim
    #2;
    chk("rst_q",     32'(dq[0]), 32'h00);
    chk("rst_rdy",   32'({drdy[0], dqv[0], dbusy[0]}), 32'b100);
    chk("rst_level", 32'(dlvl[0]), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single code 5 with defaults.
    en = 1'b1; vin = 1'b1; code = 3'd5;
    step();
    vin = 1'b0;
    chk("c5_level", 32'(dlvl[0]), 32'd1);
    step(); chk("c5_k1", 32'({dqv[0], dq[0]}), 32'h120);
    step(); chk("c5_k2", 32'({dqv[0], dq[0]}), 32'h120);
    step(); chk("c5_k3", 32'({dqv[0], dq[0]}), 32'h000);
    step(); chk("c5_busy", 32'(dbusy[0]), 32'd0);
    repeat (2) step();

    // Fill with enable low, then release.
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vin = 1'b1; code = 3'(c);
      step();
    end
    code = 3'd4;
    step();
    chk("full_level", 32'(dlvl[0]), 32'd4);
    chk("full_rdy",   32'(drdy[0]), 32'd0);
    chk("full_level1", 32'(dlvl[1]), 32'd4);
    vin = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("seq0_%0d", i), 32'(dq[0]), 32'(seq0[i]));
      chk($sformatf("seq1_%0d", i), 32'(dq[1]), 32'(seq1[i]));
    end

    // Enable dropped while code 7 is driven and code 6 is queued.
    vin = 1'b1; code = 3'd7;
    step();
    code = 3'd6;
    step();
    vin = 1'b0; en = 1'b0;
    chk("en_a1", 32'(dq[0]), 32'h80);
    step(); chk("en_a2", 32'(dq[0]), 32'h80);
    step(); chk("en_a3", 32'(dq[0]), 32'h00);
    step(); chk("en_a4", 32'(dq[0]), 32'h00);
    step(); chk("en_a5", 32'(dq[0]), 32'h00);
    en = 1'b1;
    step(); chk("en_a6", 32'(dq[0]), 32'h40);
    repeat (6) step();

    // Back-to-back words on the HOLD=1/GAP=0 instance.
    vin = 1'b1; code = 3'd3;
    step();
    code = 3'd4;
    step(); chk("b2b_0", 32'(dq[1]), 32'h08);
    code = 3'd5;
    step(); chk("b2b_1", 32'(dq[1]), 32'h10);
    vin = 1'b0;
    step(); chk("b2b_2", 32'(dq[1]), 32'h20);
    step(); chk("b2b_3", 32'(dq[1]), 32'h00);
    repeat (8) step();

    // Asynchronous reset in the middle of traffic.
    for (int c = 1; c < 5; c++) begin
      vin = 1'b1; code = 3'(c);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("arst_q",     32'({dqv[0], dq[0]}), 32'h000);
    chk("arst_rdy",   32'(drdy[0]), 32'd1);
    chk("arst_level", 32'(dlvl[0]), 32'd0);
    chk("arst_level1", 32'(dlvl[1]), 32'd0);
    vin = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      vin  = $urandom_range(0, 1) != 0;
      code = 3'($urandom_range(0, 7));
      step();
    end
    vin = 1'b0; en = 1'b1;
    repeat (40) step();
    chk("drain_level0", 32'(dlvl[0]), 32'd0);
    chk("drain_busy0",  32'(dbusy[0]), 32'd0);
    chk("drain_level1", 32'(dlvl[1]), 32'd0);
    chk("drain_busy1",  32'(dbusy[1]), 32'd0);
    chk("emitted0",     32'(emitted0), 32'(acc[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
